schoolbook_div: RTL and testbench

//  Large-integer restoring (shift-and-subtract) divider; inverse of the schoolbook multiplier.

---
 rtl/schoolbook_div_pkg.sv | 17 +
 rtl/schoolbook_div_if.sv | 31 +++
 rtl/schoolbook_div_step.sv | 28 ++
 rtl/schoolbook_div.sv | 120 ++++++++++++
 tb/tb_schoolbook_div.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/schoolbook_div_pkg.sv
// Shared definitions for the restoring large-integer divider.
//   state_t   : FSM state encoding (IDLE=0, RUN=1, DONE=2)
//   cnt_width : smallest iteration-counter width able to count 2N quotient bits
package schoolbook_div_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Counter must reach 2N-1 and satisfy 2^CW > 2N.
    function automatic int cnt_width(input int n);
        return $clog2(2 * n + 1);
    endfunction

endpackage

// File: rtl/schoolbook_div_if.sv
// Request/response bundle of the schoolbook divider.
//   start : request pulse (master -> divider)
//   a     : 2N-bit dividend (master -> divider)
//   b     : N-bit divisor (master -> divider)
//   busy  : operation in progress (divider -> master)
//   done  : one-cycle result-valid pulse (divider -> master)
//   dz    : divide-by-zero flag (divider -> master)
//   q     : 2N-bit quotient (divider -> master)
//   r     : N-bit remainder (divider -> master)
interface schoolbook_div_if #(
    parameter int N = 409
);
    logic             start;
    logic [2*N-1:0]   a;
    logic [N-1:0]     b;
    logic             busy;
    logic             done;
    logic             dz;
    logic [2*N-1:0]   q;
    logic [N-1:0]     r;

    modport master (
        output start, a, b,
        input  busy, done, dz, q, r
    );

    modport slave (
        input  start, a, b,
        output busy, done, dz, q, r
    );
endinterface

// File: rtl/schoolbook_div_step.sv
// One restoring-division iteration (purely combinational).
//   i_pr   : current partial remainder, N+1 bits (always < divisor)
//   i_bit  : next dividend bit shifted into the partial remainder
//   i_dvs  : divisor, N bits
//   o_pr   : updated partial remainder
//   o_qbit : resulting quotient bit
module schoolbook_div_step #(
    parameter int N = 409
) (
    input  logic [N:0]   i_pr,
    input  logic         i_bit,
    input  logic [N-1:0] i_dvs,
    output logic [N:0]   o_pr,
    output logic         o_qbit
);

    logic [N:0] w_t;
    logic [N:0] w_diff;
    logic       w_unused;

    // pr < dvs keeps the top bit of pr clear, so the shifted value fits N+1 bits.
    assign w_t      = {i_pr[N-1:0], i_bit};
    assign w_diff   = w_t - {1'b0, i_dvs};
    assign o_qbit   = (w_t >= {1'b0, i_dvs});
    assign o_pr     = o_qbit ? w_diff : w_t;
    assign w_unused = i_pr[N];

endmodule

// File: rtl/schoolbook_div.sv
// Restoring shift-and-subtract divider: 2N-bit dividend / N-bit divisor,
// one quotient bit per clock.
//   clk : clock, all logic on posedge
//   rst : synchronous active-high reset
//   bus : schoolbook_div_if slave (start, a, b in; busy, done, dz, q, r out)
// A zero divisor short-circuits to DONE with q = all ones, r = a[N-1:0], dz = 1.
module schoolbook_div
    import schoolbook_div_pkg::*;
#(
    parameter int N  = 409,
    parameter int CW = cnt_width(N)
) (
    input  logic           clk,
    input  logic           rst,
    schoolbook_div_if.slave bus
);

    state_t          r_state;
    state_t          w_state_nxt;

    logic [2*N-1:0]  r_dvd;      // dividend shifts out at the top, quotient bits enter at the bottom
    logic [N-1:0]    r_dvs;
    logic [N:0]      r_pr;
    logic [CW-1:0]   r_count;

    logic            r_busy;
    logic            r_done;
    logic            r_dz;
    logic [2*N-1:0]  r_q;
    logic [N-1:0]    r_r;

    logic [N:0]      w_pr_nxt;
    logic            w_qbit;
    logic            w_accept;
    logic            w_b_zero;
    logic            w_last;

    assign w_accept = (r_state == S_IDLE) && bus.start;
    assign w_b_zero = (bus.b == '0);
    assign w_last   = (r_count == CW'(2 * N - 1));

    schoolbook_div_step #(.N(N)) u_step (
        .i_pr   (r_pr),
        .i_bit  (r_dvd[2*N-1]),
        .i_dvs  (r_dvs),
        .o_pr   (w_pr_nxt),
        .o_qbit (w_qbit)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_state_nxt = w_b_zero ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Control and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_dz    <= 1'b0;
            r_q     <= '0;
            r_r     <= '0;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt != S_IDLE);
            // done trails the DONE state by one edge
            r_done  <= (r_state == S_DONE);

            if (w_accept) begin
                r_count <= '0;
                if (w_b_zero) begin
                    r_q  <= '1;
                    r_r  <= bus.a[N-1:0];
                    r_dz <= 1'b1;
                end
            end else if (r_state == S_RUN) begin
                r_count <= r_count + CW'(1);
                if (w_last) begin
                    r_q  <= {r_dvd[2*N-2:0], w_qbit};
                    r_r  <= w_pr_nxt[N-1:0];
                    r_dz <= 1'b0;
                end
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (w_accept && !w_b_zero) begin
            r_dvd <= bus.a;
            r_dvs <= bus.b;
            r_pr  <= '0;
        end else if (r_state == S_RUN) begin
            r_dvd <= {r_dvd[2*N-2:0], w_qbit};
            r_pr  <= w_pr_nxt;
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.dz   = r_dz;
    assign bus.q    = r_q;
    assign bus.r    = r_r;

endmodule

// File: tb/tb_schoolbook_div.sv
module tb_schoolbook_div;

    localparam int NS = 8;
    localparam int NW = 409;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    schoolbook_div_if #(.N(NS)) if8 ();
    schoolbook_div_if #(.N(NW)) ifw ();

    schoolbook_div #(.N(NS), .CW(5)) u_d8 (
        .clk (clk),
        .rst (rst),
        .bus (if8)
    );

    schoolbook_div #(.N(NW), .CW(10)) u_dw (
        .clk (clk),
        .rst (rst),
        .bus (ifw)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Plain-arithmetic reference for the 8-bit instance.
    task automatic model8(input logic [15:0] ma, input logic [7:0] mb,
                          output logic [15:0] eq, output logic [7:0] er, output logic edz);
        int unsigned ia;
        int unsigned ib;
        ia = ma;
        ib = mb;
        if (ib == 0) begin
            eq  = 16'hFFFF;
            er  = ma[7:0];
            edz = 1'b1;
        end else begin
            eq  = 16'(ia / ib);
            er  = 8'(ia % ib);
            edz = 1'b0;
        end
    endtask

    task automatic run8(input logic [15:0] ta, input logic [7:0] tbv,
                        output int lat, output logic [15:0] oq, output logic [7:0] orr,
                        output logic odz);
        if8.a     = ta;
        if8.b     = tbv;
        if8.start = 1'b1;
        tick();
        if8.start = 1'b0;
        if8.a     = 16'($urandom());
        if8.b     = 8'($urandom());
        lat = 0;
        while (!if8.done && lat < 100) begin
            tick();
            lat++;
        end
        oq  = if8.q;
        orr = if8.r;
        odz = if8.dz;
    endtask

    task automatic check8(input string name, input logic [15:0] ta, input logic [7:0] tbv);
        int          lat;
        logic [15:0] oq, eq;
        logic [7:0]  orr, er;
        logic        odz, edz;
        int          elat;
        model8(ta, tbv, eq, er, edz);
        elat = (tbv == 0) ? 1 : 2 * NS + 1;
        run8(ta, tbv, lat, oq, orr, odz);
        checks++;
        if (lat !== elat) begin
            failures++;
            $display("FAIL %s latency a=%0d b=%0d got=%0d exp=%0d", name, ta, tbv, lat, elat);
        end
        checks++;
        if (oq !== eq || orr !== er || odz !== edz) begin
            failures++;
            $display("FAIL %s result a=%0d b=%0d got q=%0d r=%0d dz=%0b exp q=%0d r=%0d dz=%0b",
                     name, ta, tbv, oq, orr, odz, eq, er, edz);
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        if8.start = 1'b0;
        ifw.start = 1'b0;
        if8.a = '0; if8.b = '0;
        ifw.a = '0; ifw.b = '0;
        tick();
        tick();
        rst = 1'b0;
        checks++;
        if ({if8.busy, if8.done, if8.dz} !== 3'b000 || if8.q !== '0 || if8.r !== '0) begin
            failures++;
            $display("FAIL reset8 got busy=%0b done=%0b dz=%0b q=%0h r=%0h exp all zero",
                     if8.busy, if8.done, if8.dz, if8.q, if8.r);
        end
        checks++;
        if ({ifw.busy, ifw.done, ifw.dz} !== 3'b000 || ifw.q !== '0 || ifw.r !== '0) begin
            failures++;
            $display("FAIL resetw got busy=%0b done=%0b dz=%0b exp all zero",
                     ifw.busy, ifw.done, ifw.dz);
        end
    endtask

    task automatic test_basic();
        check8("basic_1000_7", 16'd1000, 8'd7);
        // done must be a single-cycle pulse and results must hold afterwards
        tick();
        checks++;
        if (if8.done !== 1'b0) begin
            failures++;
            $display("FAIL done_pulse got=%0b exp=0", if8.done);
        end
        repeat (3) tick();
        checks++;
        if (if8.q !== 16'd142 || if8.r !== 8'd6 || if8.busy !== 1'b0) begin
            failures++;
            $display("FAIL hold got q=%0d r=%0d busy=%0b exp q=142 r=6 busy=0", if8.q, if8.r, if8.busy);
        end
    endtask

    task automatic test_back_to_back();
        // second request issued in the cycle done is high
        check8("max_ffff_ff", 16'hFFFF, 8'hFF);
        check8("small_5_200", 16'd5, 8'd200);
        check8("zero_dividend", 16'd0, 8'd3);
    endtask

    task automatic test_div_zero();
        check8("divzero_1234", 16'd1234, 8'd0);
        checks++;
        if (if8.q !== 16'hFFFF || if8.r !== 8'hD2) begin
            failures++;
            $display("FAIL divzero_vals got q=%0h r=%0h exp q=ffff r=d2", if8.q, if8.r);
        end
        check8("after_dz", 16'd77, 8'd10);
    endtask

    task automatic test_random8();
        logic [15:0] ra;
        logic [7:0]  rb;
        for (int i = 0; i < 30; i++) begin
            ra = 16'($urandom());
            rb = 8'($urandom());
            if (i % 7 == 3) rb = 8'd0;
            if (i % 5 == 1) ra = 16'(rb) >> 1;
            check8("random8", ra, rb);
        end
    endtask

    task automatic test_start_held();
        int          pulses;
        int          lat;
        logic [15:0] gq;
        logic [7:0]  gr;
        pulses = 0;
        lat    = -1;
        gq = '0; gr = '0;
        if8.a     = 16'd600;
        if8.b     = 8'd13;
        if8.start = 1'b1;
        tick();
        for (int i = 0; i < 2 * NS + 6; i++) begin
            if (i < 10) begin
                if8.a = 16'($urandom());
                if8.b = 8'($urandom());
            end else begin
                if8.start = 1'b0;
            end
            tick();
            if (if8.done) begin
                pulses++;
                lat = i + 1;
                gq  = if8.q;
                gr  = if8.r;
            end
        end
        checks++;
        if (pulses !== 1 || lat !== 2 * NS + 1) begin
            failures++;
            $display("FAIL start_held pulses got=%0d exp=1 latency got=%0d exp=%0d", pulses, lat, 2 * NS + 1);
        end
        checks++;
        if (gq !== 16'(600 / 13) || gr !== 8'(600 % 13)) begin
            failures++;
            $display("FAIL start_held result got q=%0d r=%0d exp q=%0d r=%0d", gq, gr, 600 / 13, 600 % 13);
        end
    endtask

    task automatic test_reset_mid();
        if8.a     = 16'd50000;
        if8.b     = 8'd37;
        if8.start = 1'b1;
        tick();
        if8.start = 1'b0;
        repeat (5) tick();
        checks++;
        if (if8.busy !== 1'b1) begin
            failures++;
            $display("FAIL busy_in_run got=%0b exp=1", if8.busy);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (if8.busy !== 1'b0 || if8.done !== 1'b0 || if8.dz !== 1'b0 || if8.q !== '0 || if8.r !== '0) begin
            failures++;
            $display("FAIL reset_mid got busy=%0b done=%0b dz=%0b q=%0d r=%0d exp all zero",
                     if8.busy, if8.done, if8.dz, if8.q, if8.r);
        end
        check8("after_reset", 16'd200, 8'd9);
    endtask

    function automatic logic [2*NW-1:0] rand_bits(input int nb);
        logic [2*NW-1:0] v;
        logic [2*NW-1:0] m;
        v = '0;
        for (int i = 0; i < (2 * NW + 31) / 32; i++) begin
            v = {v[2*NW-33:0], 32'($urandom())};
        end
        m = '1;
        m = m >> (2 * NW - nb);
        return v & m;
    endfunction

    // Schoolbook (shift-and-add) multiplier model.
    function automatic logic [3*NW-1:0] mul_model(input logic [2*NW-1:0] x, input logic [NW-1:0] y);
        logic [3*NW-1:0] acc;
        acc = '0;
        for (int i = 0; i < NW; i++) begin
            if (y[i]) acc = acc + ({{NW{1'b0}}, x} << i);
        end
        return acc;
    endfunction

    task automatic test_wide();
        logic [2*NW-1:0] x, tmp, ea, gq;
        logic [NW-1:0]   y, rr, gr;
        int              ly, lat;
        for (int n = 0; n < 50; n++) begin
            ly  = $urandom_range(1, NW);
            tmp = rand_bits(ly);
            tmp[ly-1] = 1'b1;
            y   = tmp[NW-1:0];
            x   = rand_bits(2 * NW - ly);
            tmp = rand_bits(NW);
            rr  = tmp[NW-1:0] % y;
            ea  = x * y + rr;
            ifw.a     = ea;
            ifw.b     = y;
            ifw.start = 1'b1;
            tick();
            ifw.start = 1'b0;
            ifw.a     = rand_bits(2 * NW);
            lat = 0;
            while (!ifw.done && lat < 2000) begin
                tick();
                lat++;
            end
            gq = ifw.q;
            gr = ifw.r;
            checks++;
            if (lat !== 2 * NW + 1) begin
                failures++;
                $display("FAIL wide_latency run=%0d got=%0d exp=%0d", n, lat, 2 * NW + 1);
            end
            checks++;
            if (gq !== x || gr !== rr || ifw.dz !== 1'b0) begin
                failures++;
                $display("FAIL wide_result run=%0d got q=%0h r=%0h exp q=%0h r=%0h", n, gq, gr, x, rr);
            end
            checks++;
            if (mul_model(gq, y) + {{2*NW{1'b0}}, gr} !== {{NW{1'b0}}, ea}) begin
                failures++;
                $display("FAIL wide_recompose run=%0d q*b+r does not equal a", n);
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_div_zero();
        test_random8();
        test_start_held();
        test_reset_mid();
        test_wide();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
